// File: rtl/segscan_decoder.sv
// Receive side of the multiplexed 7-segment bus: stability-qualifies each digit dwell,
// decodes its pattern into a per-digit slot and presents completed frames on valid/ready.
module segscan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic [NUM_DIGITS-1:0]   out_bad,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    state_t                         state, state_n;
    logic [CW-1:0]                  cnt, cnt_n;
    logic                           capture;
    logic [NUM_DIGITS-1:0]          sel_r, sel_p;
    logic [6:0]                     seg_r, seg_p;
    logic [NUM_DIGITS-1:0]          mask;
    logic [NUM_DIGITS-1:0][3:0]     slot_code, code_n;
    logic [NUM_DIGITS-1:0]          slot_bad, bad_n;
    logic [3:0]                     dec_code;
    logic                           dec_bad;
    logic                           changed, onehot, mask_full, load;

    assign changed   = ({sel_r, seg_r} != {sel_p, seg_p});
    assign onehot    = $onehot(sel_r);
    assign mask_full = &mask;
    assign load      = mask_full && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sel_r <= '0;
            seg_r <= '0;
            sel_p <= '0;
            seg_p <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sel_r <= dig_sel;
            seg_r <= seg_in;
            sel_p <= sel_r;
            seg_p <= seg_r;
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt holds (samples seen stable - 1); capture fires on the STABLE_CYCLES-th sample
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (onehot) state_n = COUNT;
            end
            COUNT: begin
                if (changed) begin
                    state_n = onehot ? COUNT : IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    capture = 1'b1;
                    state_n = HELD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (changed) begin
                    state_n = onehot ? COUNT : IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        dec_code = 4'hF;
        dec_bad  = 1'b0;
        case (seg_r)
            7'h3F: dec_code = 4'h0;
            7'h06: dec_code = 4'h1;
            7'h5B: dec_code = 4'h2;
            7'h4F: dec_code = 4'h3;
            7'h66: dec_code = 4'h4;
            7'h6D: dec_code = 4'h5;
            7'h7C: dec_code = 4'h6;
            7'h07: dec_code = 4'h7;
            7'h7F: dec_code = 4'h8;
            7'h67: dec_code = 4'h9;
            7'h40: dec_code = 4'hA;
            7'h00: dec_code = 4'hF;
            default: begin
                dec_code = 4'hF;
                dec_bad  = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
        assign code_n[i] = (capture && sel_r[i]) ? dec_code : slot_code[i];
        assign bad_n[i]  = (capture && sel_r[i]) ? dec_bad  : slot_bad[i];
    end

    // Slots survive a frame hand-off; only the mask is cleared so every digit must be recaptured
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot_code <= '0;
            slot_bad  <= '0;
            mask      <= '0;
        end else begin
            slot_code <= code_n;
            slot_bad  <= bad_n;
            mask      <= (mask_full ? '0 : mask) | (capture ? sel_r : '0);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_digits <= '0;
            out_bad    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= mask_full && out_valid && !out_ready;
            if (load) begin
                out_digits <= slot_code;
                out_bad    <= slot_bad;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_segscan_decoder.sv
// Scoreboard bench for segscan_decoder: expected frames are queued as digit dwells are
// driven and popped when the decoder presents a frame.
module tb_segscan_decoder;

    localparam int ND = 4;
    localparam int SC = 16;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic [6:0]      seg_in = '0;
    logic [ND-1:0]   dig_sel = '0;
    logic [4*ND-1:0] out_digits;
    logic [ND-1:0]   out_bad;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            overrun;

    typedef struct packed {
        logic [4*ND-1:0] d;
        logic [ND-1:0]   b;
    } frame_t;

    frame_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int ov_count = 0;

    logic [6:0] pat_tab  [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C,
                                  7'h07, 7'h7F, 7'h67, 7'h40, 7'h00, 7'h01};
    logic [3:0] code_tab [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h7, 4'h8, 4'h9, 4'hA, 4'hF, 4'hF};
    logic       bad_tab  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    segscan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .n_reset(n_reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .out_digits(out_digits), .out_bad(out_bad), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun) ov_count++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1);
    end

    function automatic frame_t mk(input logic [4*ND-1:0] d, input logic [ND-1:0] b);
        frame_t f;
        f.d = d;
        f.b = b;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d, input logic [6:0] seg, input int cyc);
        dig_sel = ND'(1 << d);
        seg_in  = seg;
        repeat (cyc) tick();
    endtask

    task automatic drive_frame(input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0, input int cyc);
        drive_digit(3, s3, cyc);
        drive_digit(2, s2, cyc);
        drive_digit(1, s1, cyc);
        drive_digit(0, s0, cyc);
        dig_sel = '0;
        seg_in  = '0;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_activity(input int cyc, output int act);
        act = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (out_valid || overrun) act++;
        end
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        dig_sel   = '0;
        seg_in    = '0;
        n_reset   = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        frame_t e;
        bit seen;
        int act;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        n_cmp++; if (out_digits !== '0) begin n_err++; $display("FAIL rst_digits: got %h expected 0000", out_digits); end
        n_cmp++; if (out_bad !== '0) begin n_err++; $display("FAIL rst_bad: got %b expected 0000", out_bad); end
        n_reset = 1'b1;
        tick();
        sb.push_back(mk(16'h0123, 4'b0000));
        drive_frame(7'h3F, 7'h06, 7'h5B, 7'h4F, 20);
        wait_valid(40, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || out_digits !== e.d) begin n_err++; $display("FAIL rst_preframe: got valid=%b digits=%h expected valid=1 digits=%h", seen, out_digits, e.d); end
        drive_digit(3, 7'h66, 8);
        #3 n_reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
        n_cmp++; if (out_digits !== '0) begin n_err++; $display("FAIL rst_mid_digits: got %h expected 0000", out_digits); end
        n_cmp++; if (out_bad !== '0) begin n_err++; $display("FAIL rst_mid_bad: got %b expected 0000", out_bad); end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        tick();
        drive_digit(0, 7'h3F, 20);
        dig_sel = '0;
        count_activity(25, act);
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL rst_partial: got %0d active cycles expected 0", act); end
    endtask

    task automatic test_basic();
        frame_t e;
        bit seen;
        do_reset();
        sb.push_back(mk(16'h3456, 4'b0000));
        drive_frame(7'h4F, 7'h66, 7'h6D, 7'h7C, 20);
        wait_valid(40, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen) begin n_err++; $display("FAIL basic_valid: got timeout expected out_valid=1"); end
        n_cmp++; if (out_digits !== e.d) begin n_err++; $display("FAIL basic_digits: got %h expected %h", out_digits, e.d); end
        n_cmp++; if (out_bad !== e.b) begin n_err++; $display("FAIL basic_bad: got %b expected %b", out_bad, e.b); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_accept: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_sweep();
        frame_t e;
        bit seen;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            sb.push_back(mk({12'h000, code_tab[i]}, {3'b000, bad_tab[i]}));
            drive_frame(7'h3F, 7'h3F, 7'h3F, pat_tab[i], 18);
            wait_valid(40, seen);
            e = sb.pop_front();
            n_cmp++; if (!seen || out_digits !== e.d) begin n_err++; $display("FAIL sweep_digits[%0d]: got valid=%b digits=%h expected %h", i, seen, out_digits, e.d); end
            n_cmp++; if (out_bad !== e.b) begin n_err++; $display("FAIL sweep_bad[%0d]: got %b expected %b", i, out_bad, e.b); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_glitch();
        frame_t e;
        bit seen;
        int act;
        do_reset();
        drive_digit(3, 7'h06, 18);
        drive_digit(2, 7'h06, 18);
        drive_digit(1, 7'h06, 18);
        drive_digit(0, 7'h3F, 10);
        drive_digit(0, 7'h3E, 1);
        drive_digit(0, 7'h3F, 15);
        dig_sel = '0;
        count_activity(25, act);
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL glitch_15: got %0d active cycles expected 0", act); end
        sb.push_back(mk(16'h1110, 4'b0000));
        drive_digit(0, 7'h3F, 10);
        drive_digit(0, 7'h3E, 1);
        drive_digit(0, 7'h3F, 16);
        dig_sel = '0;
        wait_valid(10, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || out_digits !== e.d) begin n_err++; $display("FAIL glitch_16: got valid=%b digits=%h expected %h", seen, out_digits, e.d); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        do_reset();
        drive_digit(3, 7'h06, 18);
        drive_digit(2, 7'h06, 18);
        dig_sel = 4'b0011;
        seg_in  = 7'h3F;
        repeat (30) tick();
        dig_sel = '0;
        count_activity(25, act);
        n_cmp++; if (act !== 0) begin n_err++; $display("FAIL multisel: got %0d active cycles expected 0", act); end
        sb.push_back(mk(16'h1100, 4'b0000));
        drive_digit(1, 7'h3F, 18);
        drive_digit(0, 7'h3F, 18);
        dig_sel = '0;
        wait_valid(20, seen);
        e = sb.pop_front();
        n_cmp++; if (!seen || out_digits !== e.d) begin n_err++; $display("FAIL multisel_after: got valid=%b digits=%h expected %h", seen, out_digits, e.d); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        frame_t e;
        bit seen;
        int ov0;
        do_reset();
        sb.push_back(mk(16'h3456, 4'b0000));
        drive_frame(7'h4F, 7'h66, 7'h6D, 7'h7C, 20);
        wait_valid(40, seen);
        e = sb[0];
        n_cmp++; if (!seen || out_digits !== e.d) begin n_err++; $display("FAIL bp_first: got valid=%b digits=%h expected %h", seen, out_digits, e.d); end
        ov0 = ov_count;
        drive_frame(7'h7F, 7'h67, 7'h40, 7'h00, 20);
        repeat (10) tick();
        n_cmp++; if (ov_count - ov0 !== 1) begin n_err++; $display("FAIL bp_overrun: got %0d pulses expected 1", ov_count - ov0); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_digits !== e.d) begin n_err++; $display("FAIL bp_held_digits: got %h expected %h", out_digits, e.d); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_ready_same: got valid=%b expected 1", out_valid); end
        tick();
        out_ready = 1'b0;
        void'(sb.pop_front());
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        frame_t e;
        bit seen;
        int ov0;
        do_reset();
        sb.push_back(mk(16'h0123, 4'b0000));
        drive_frame(7'h3F, 7'h06, 7'h5B, 7'h4F, 20);
        wait_valid(40, seen);
        n_cmp++; if (!seen || out_digits !== sb[0].d) begin n_err++; $display("FAIL b2b_first: got valid=%b digits=%h expected %h", seen, out_digits, sb[0].d); end
        ov0 = ov_count;
        sb.push_back(mk(16'h789A, 4'b0000));
        drive_digit(3, 7'h07, 20);
        drive_digit(2, 7'h7F, 20);
        drive_digit(1, 7'h67, 20);
        dig_sel = 4'b0001;
        seg_in  = 7'h40;
        // mask is full in cycle 17 of the last dwell: ready only in that cycle
        repeat (17) tick();
        out_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_digits !== e.d) begin n_err++; $display("FAIL b2b_before: got valid=%b digits=%h expected 1 %h", out_valid, out_digits, e.d); end
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_digits !== e.d) begin n_err++; $display("FAIL b2b_digits: got %h expected %h", out_digits, e.d); end
        n_cmp++; if (out_bad !== e.b) begin n_err++; $display("FAIL b2b_bad: got %b expected %b", out_bad, e.b); end
        n_cmp++; if (ov_count !== ov0) begin n_err++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ov_count - ov0); end
        dig_sel = '0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_glitch();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
